cpu_dram_timing_gen: RTL and testbench
======================================

Name: cpu_dram_timing_gen

Overview:
Parametrised successor of the gate-array CPU clock / DRAM sequencer, derived from a master clock.
- Generates the 6809E quadrature clocks E, nE and Q.
- Time-multiplexes one DRAM between a video slot (E low) and a CPU slot (E high).
- Inserts RAS-only refresh cycles with a wrapping row counter.
- Supports clock stall via PIN_SYCL.
- Divider, refresh rate, row width and video-slot enable are generic. The fixed-ratio version lacked the refresh counter and stall handling.

Parameters:
DIV, 16, master clocks per E cycle; multiple of 4, >= 12
REFRESH_EVERY, 64, completed E cycles between refresh slots; >= 2
ROW_W, 7, refresh row counter width
VIDEO_EN, 1, 1 = E-low half carries a video slot; 0 = idle unless refresh

Ports:
PIN_H16  in  1  master clock, all logic on rising edge
PIN_58  in  1  reset, asynchronous, active-low
PIN_SYCL  in  1  stall request, sampled at ph==DIV-1
CPU_SEL  in  1  CPU wants DRAM, sampled at ph==DIV/2-1
PIN_RW  in  1  CPU read(1)/write(0), sampled with CPU_SEL
E  out  1  6809 E clock
nE  out  1  inverse of E
Q  out  1  6809 Q clock, leads E by DIV/4
PIN_nRAS  out  1  DRAM row strobe, active-low
PIN_nCAS  out  1  DRAM column strobe, active-low
PIN_MUX  out  1  address mux: 0 = row, 1 = column
PIN_nWE  out  1  DRAM write enable, active-low
SLOT  out  2  current slot: 00 idle, 01 video, 10 cpu, 11 refresh
REF_ROW  out  ROW_W  refresh row address

Behaviour:
Reset (PIN_58 low, immediate, also mid-slot):
- ph=0, E=0, nE=1, Q=0.
- nRAS=nCAS=nWE=1, MUX=0, SLOT=00.
- REF_ROW=0, refresh cycle counter=0, ref_pending=0.
- First ph advance is on the first clock edge after PIN_58 goes high.

Phase counter ph, range 0..DIV-1, wraps DIV-1 -> 0. Outputs are registered and reflect ph:
- E = (ph >= DIV/2).
- Q = (ph >= DIV/4 && ph < 3*DIV/4).
- nE = ~E.
- One E period = DIV clocks, 50% duty. Q rises DIV/4 clocks before E.

Stall:
- If PIN_SYCL=1 at ph==DIV-1, ph goes to 0 and freezes there while PIN_SYCL=1; E=Q=0 is held.
- The edge after PIN_SYCL samples 0 advances ph to 1.
- No slot starts while frozen. A frozen E cycle is not counted for refresh.

Slots: H = DIV/2. Each half-cycle is one slot, with offset o = ph mod H.
- Low half (ph 0..H-1):
  - Refresh if ref_pending.
  - Else video if VIDEO_EN.
  - Else idle.
- High half (ph H..DIV-1): CPU if CPU_SEL=1 at ph==H-1, else idle. PIN_RW is latched at the same edge.
- SLOT is updated at o==0 and held for the whole half.

Strobe sequence within an active slot:
- o==1: nRAS=0.
- o==2: MUX=1.
- o==3: nCAS=0, except in a refresh slot, where nCAS stays 1 (RAS-only).
- CPU write (latched RW=0): nWE=0 from o==2 through o==H-1.
- o==H-1: nRAS=nCAS=nWE=1 and MUX=0 on the next edge, i.e. all are inactive at the next o==0.
- Idle slot: all strobes inactive.

Refresh:
- The cycle counter increments at each non-frozen ph DIV-1 -> 0 transition.
- When it reaches REFRESH_EVERY-1 it resets to 0 and sets ref_pending. The refresh therefore occupies the very next low half.
- At the end of the refresh slot (o==H-1): REF_ROW increments, wrapping 2^ROW_W-1 -> 0, and ref_pending clears.
- Refresh overrides video. CPU slots are never displaced.

Test Plan:
1. Reset, release PIN_58, DIV=16 -> E period 16 clocks with high at ph 8..15; Q high ph 4..11; nE==~E; all strobes 1 during reset.
2. CPU_SEL=1, PIN_RW=1 at ph 7 -> SLOT=10 for ph 8..15; nRAS low ph 9..15, MUX 1 ph 10..15, nCAS low ph 11..15, nWE stays 1.
3. CPU_SEL=1, PIN_RW=0 -> nWE low ph 10..15 of the high half, 1 elsewhere; SLOT=01 with full RAS/CAS in each low half.
4. Free run 64 E cycles -> next low half has SLOT=11 with nRAS pulse and nCAS held 1; REF_ROW 0->1 afterwards; after 128*64 cycles REF_ROW wraps 127->0.
5. PIN_SYCL=1 at ph 15 held 5 clocks -> ph frozen at 0, E=Q=0, no strobes, refresh counter unchanged; resumes at ph 1 one edge after release.
6. Assert PIN_58 at ph 12 of a CPU write -> nRAS, nCAS and nWE go 1 immediately and E=0; clean restart from ph 0.

Source files
------------

// File: rtl/cpu_dram_timing_gen.sv
// 6809E E/Q clock generator and DRAM slot sequencer (video / CPU / RAS-only refresh).
// Latency: every output is registered and tracks the phase counter in the same cycle.
// Backpressure: PIN_SYCL freezes the phase at 0 from the end of an E cycle until it drops.
module cpu_dram_timing_gen #(
    parameter int DIV           = 16,
    parameter int REFRESH_EVERY = 64,
    parameter int ROW_W         = 7,
    parameter int VIDEO_EN      = 1
) (
    input  logic             PIN_H16,
    input  logic             PIN_58,
    input  logic             PIN_SYCL,
    input  logic             CPU_SEL,
    input  logic             PIN_RW,
    output logic             E,
    output logic             nE,
    output logic             Q,
    output logic             PIN_nRAS,
    output logic             PIN_nCAS,
    output logic             PIN_MUX,
    output logic             PIN_nWE,
    output logic [1:0]       SLOT,
    output logic [ROW_W-1:0] REF_ROW
);

    localparam int H     = DIV / 2;
    localparam int PH_W  = $clog2(DIV);
    localparam int CNT_W = $clog2(REFRESH_EVERY);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(H - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(H);
    localparam logic [PH_W-1:0]  PH_Q_ON  = PH_W'(DIV / 4);
    localparam logic [PH_W-1:0]  PH_Q_OFF = PH_W'(3 * DIV / 4);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_TWO   = PH_W'(2);
    localparam logic [PH_W-1:0]  PH_THREE = PH_W'(3);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_EVERY - 1);

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'b00,
        SLOT_VIDEO = 2'b01,
        SLOT_CPU   = 2'b10,
        SLOT_REF   = 2'b11
    } slot_t;

    logic [PH_W-1:0]  ph, ph_nxt;
    logic             frozen, frozen_nxt;
    logic [CNT_W-1:0] cyc_cnt, cyc_cnt_nxt;
    logic             ref_pending, ref_pending_nxt;
    logic [ROW_W-1:0] ref_row_nxt;
    slot_t            slot_q, slot_nxt;
    logic             rw_q, rw_nxt;
    logic [PH_W-1:0]  off_nxt;
    logic             active_nxt;

    always_comb begin
        ph_nxt          = ph;
        frozen_nxt      = frozen;
        cyc_cnt_nxt     = cyc_cnt;
        ref_pending_nxt = ref_pending;
        ref_row_nxt     = REF_ROW;
        slot_nxt        = slot_q;
        rw_nxt          = rw_q;

        if (frozen) begin
            // Release steps straight to ph 1; the low half stays idle because its o==0 edge was spent frozen.
            if (!PIN_SYCL) begin
                frozen_nxt = 1'b0;
                ph_nxt     = PH_ONE;
            end
        end else if (ph == PH_LAST) begin
            ph_nxt     = '0;
            frozen_nxt = PIN_SYCL;
            if (cyc_cnt == CNT_LAST) begin
                cyc_cnt_nxt     = '0;
                ref_pending_nxt = 1'b1;
            end else begin
                cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
            end
            if (PIN_SYCL) begin
                slot_nxt = SLOT_IDLE;
            end else if (ref_pending_nxt) begin
                slot_nxt = SLOT_REF;
            end else if (VIDEO_EN != 0) begin
                slot_nxt = SLOT_VIDEO;
            end else begin
                slot_nxt = SLOT_IDLE;
            end
        end else if (ph == PH_MID) begin
            if (slot_q == SLOT_REF) begin
                ref_row_nxt     = REF_ROW + ROW_W'(1);
                ref_pending_nxt = 1'b0;
            end
            ph_nxt   = ph + PH_ONE;
            slot_nxt = CPU_SEL ? SLOT_CPU : SLOT_IDLE;
            rw_nxt   = PIN_RW;
        end else begin
            ph_nxt = ph + PH_ONE;
        end

        off_nxt    = (ph_nxt >= PH_HALF) ? (ph_nxt - PH_HALF) : ph_nxt;
        active_nxt = (slot_nxt != SLOT_IDLE);
    end

    always_ff @(posedge PIN_H16 or negedge PIN_58) begin
        if (!PIN_58) begin
            ph          <= '0;
            frozen      <= 1'b0;
            cyc_cnt     <= '0;
            ref_pending <= 1'b0;
            REF_ROW     <= '0;
            slot_q      <= SLOT_IDLE;
            rw_q        <= 1'b1;
            E           <= 1'b0;
            nE          <= 1'b1;
            Q           <= 1'b0;
            PIN_nRAS    <= 1'b1;
            PIN_nCAS    <= 1'b1;
            PIN_MUX     <= 1'b0;
            PIN_nWE     <= 1'b1;
        end else begin
            ph          <= ph_nxt;
            frozen      <= frozen_nxt;
            cyc_cnt     <= cyc_cnt_nxt;
            ref_pending <= ref_pending_nxt;
            REF_ROW     <= ref_row_nxt;
            slot_q      <= slot_nxt;
            rw_q        <= rw_nxt;
            E           <= (ph_nxt >= PH_HALF);
            nE          <= ~(ph_nxt >= PH_HALF);
            Q           <= (ph_nxt >= PH_Q_ON) && (ph_nxt < PH_Q_OFF);
            // Strobes are a pure function of slot and offset, so o==0 is always inactive.
            PIN_nRAS    <= ~(active_nxt && (off_nxt >= PH_ONE));
            PIN_MUX     <= active_nxt && (off_nxt >= PH_TWO);
            PIN_nCAS    <= ~(active_nxt && (slot_nxt != SLOT_REF) && (off_nxt >= PH_THREE));
            PIN_nWE     <= ~((slot_nxt == SLOT_CPU) && !rw_nxt && (off_nxt >= PH_TWO));
        end
    end

    assign SLOT = slot_q;

endmodule

// File: tb/tb_cpu_dram_timing_gen.sv
// Randomized scoreboard bench for cpu_dram_timing_gen with an arithmetic reference model.
module tb_cpu_dram_timing_gen;

    localparam int DIV   = 16;
    localparam int H     = DIV / 2;
    localparam int RE    = 16;
    localparam int ROW_W = 3;
    localparam int NROWS = 1 << ROW_W;
    localparam int VW    = 9 + ROW_W;
    localparam int NCYC  = 6000;

    logic PIN_H16 = 1'b0;
    logic PIN_58  = 1'b1;
    logic PIN_SYCL = 1'b0;
    logic CPU_SEL  = 1'b0;
    logic PIN_RW   = 1'b1;
    logic E, nE, Q, PIN_nRAS, PIN_nCAS, PIN_MUX, PIN_nWE;
    logic [1:0]       SLOT;
    logic [ROW_W-1:0] REF_ROW;

    cpu_dram_timing_gen #(
        .DIV(DIV), .REFRESH_EVERY(RE), .ROW_W(ROW_W), .VIDEO_EN(1)
    ) dut (
        .PIN_H16(PIN_H16), .PIN_58(PIN_58), .PIN_SYCL(PIN_SYCL), .CPU_SEL(CPU_SEL),
        .PIN_RW(PIN_RW), .E(E), .nE(nE), .Q(Q), .PIN_nRAS(PIN_nRAS), .PIN_nCAS(PIN_nCAS),
        .PIN_MUX(PIN_MUX), .PIN_nWE(PIN_nWE), .SLOT(SLOT), .REF_ROW(REF_ROW)
    );

    always #5 PIN_H16 = ~PIN_H16;

    typedef enum int {K_IDLE, K_VID, K_CPU, K_REF} kind_e;

    int    n_vec = 0;
    int    n_err = 0;
    int    m_ph, m_cycles, m_row;
    bit    m_frozen, m_due, m_wr;
    kind_e m_kind;
    logic [VW-1:0] sb[$];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {E, nE, Q, PIN_nRAS, PIN_nCAS, PIN_MUX, PIN_nWE, SLOT, REF_ROW};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        int   o   = m_ph % H;
        bit   act = (m_kind != K_IDLE);
        bit   e   = (m_ph >= H);
        bit   q   = (m_ph >= DIV / 4) && (m_ph < 3 * DIV / 4);
        bit   nras = !(act && o >= 1);
        bit   mux  = act && o >= 2;
        bit   ncas = !(act && m_kind != K_REF && o >= 3);
        bit   nwe  = !(m_kind == K_CPU && m_wr && o >= 2);
        logic [1:0] s;
        logic [ROW_W-1:0] r = ROW_W'(m_row);
        case (m_kind)
            K_VID:   s = 2'b01;
            K_CPU:   s = 2'b10;
            K_REF:   s = 2'b11;
            default: s = 2'b00;
        endcase
        return {e, !e, q, nras, ncas, mux, nwe, s, r};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cycles = 0; m_row = 0;
        m_frozen = 0; m_due = 0; m_wr = 0;
        m_kind = K_IDLE;
    endtask

    // Advances the model across one rising edge given the inputs present at that edge.
    task automatic model_step(input bit rst, input bit sycl, input bit sel, input bit rw);
        if (!rst) begin
            model_reset();
        end else if (m_frozen) begin
            if (!sycl) begin
                m_frozen = 0;
                m_ph = 1;
            end
        end else if (m_ph == DIV - 1) begin
            m_ph = 0;
            m_cycles++;
            if (m_cycles == RE) begin
                m_cycles = 0;
                m_due = 1;
            end
            m_frozen = sycl;
            if (sycl)       m_kind = K_IDLE;
            else if (m_due) m_kind = K_REF;
            else            m_kind = K_VID;
        end else if (m_ph == H - 1) begin
            if (m_kind == K_REF) begin
                m_row = (m_row + 1) % NROWS;
                m_due = 0;
            end
            m_ph   = H;
            m_kind = sel ? K_CPU : K_IDLE;
            m_wr   = !rw;
        end else begin
            m_ph++;
        end
    endtask

    initial begin
        forever begin
            @(posedge PIN_H16);
            #2;
            if (sb.size() > 0) check("outputs", dut_vec(), sb.pop_front());
        end
    end

    initial begin
        logic [VW-1:0] rst_vec;
        bit rst, sycl, sel, rw;
        int hold = 0;
        int rs_state = 0;
        int rs_hold = 0;
        rst_vec = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, {ROW_W{1'b0}}};
        model_reset();
        #1 PIN_58 = 1'b0;
        #2 check("reset_state", dut_vec(), rst_vec);

        for (int n = 0; n < NCYC; n++) begin
            @(negedge PIN_H16);
            rst = 1'b1;
            sel = ($urandom_range(0, 1) == 1);
            rw  = ($urandom_range(0, 1) == 1);
            if (hold > 0) begin
                sycl = 1'b1;
                hold--;
            end else if (m_ph == DIV - 1 && $urandom_range(0, 4) == 0) begin
                sycl = 1'b1;
                hold = $urandom_range(0, 5);
            end else begin
                sycl = ($urandom_range(0, 7) == 0);
            end
            if (n < 3) rst = 1'b0;
            if (n == 3000) rs_state = 1;

            if (rs_state == 1 && m_ph == H - 1 && !m_frozen) begin
                sel = 1'b1;
                rw  = 1'b0;
                rs_state = 2;
            end else if (rs_state == 2 && m_ph == 12) begin
                rst = 1'b0;
                rs_state = 3;
                rs_hold = 2;
            end else if (rs_state == 3) begin
                if (rs_hold > 0) begin
                    rst = 1'b0;
                    rs_hold--;
                end else begin
                    rs_state = 0;
                end
            end

            PIN_SYCL = sycl;
            CPU_SEL  = sel;
            PIN_RW   = rw;
            PIN_58   = rst;
            if (!rst && rs_state == 3 && rs_hold == 2) begin
                #1;
                check("async_reset_mid_write", dut_vec(), rst_vec);
            end
            model_step(rst, sycl, sel, rw);
            sb.push_back(model_vec());
        end

        repeat (2) @(posedge PIN_H16);
        #3;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
